// File: rtl/rank_order_pkg.sv
// Shared constants and helpers for the 3x3 rank-order selector.
package rank_order_pkg;

    localparam int N_TAPS               = 9;
    localparam int RANK_W               = 4;
    localparam int DEFAULT_ORDER_MEDIAN = 5;

    localparam logic [RANK_W-1:0] MAX_RANK_IDX = RANK_W'(N_TAPS - 1);

    // Converts a 1-based requested rank into a 0-based rank index.
    // Zero is treated as the minimum and anything above nine as the maximum.
    function automatic logic [RANK_W-1:0] clampRankIndex(input logic [RANK_W-1:0] order);
        logic [RANK_W-1:0] idx;
        if (order == '0) begin
            idx = '0;
        end else if (order > RANK_W'(N_TAPS)) begin
            idx = MAX_RANK_IDX;
        end else begin
            idx = order - RANK_W'(1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rank_count.sv
// Computes the unique ascending rank of one window sample against the
// other eight. Equal values are ordered by their original window index,
// so the nine ranks always form a permutation of 0..8.
module rank_count
    import rank_order_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]               iSample,
    input  logic [RANK_W-1:0]               iIndex,
    input  logic [N_TAPS-2:0][DATA_W-1:0]   iOthers,
    output logic [RANK_W-1:0]               oRank
);

    logic [RANK_W-1:0] w_count;

    // Others slot k holds original index k below our own index and k+1 at or
    // above it, so "earlier equal sample" reduces to k < iIndex.
    always_comb begin
        w_count = '0;
        for (int k = 0; k < N_TAPS - 1; k++) begin
            if ((iOthers[k] < iSample) ||
                ((iOthers[k] == iSample) && (RANK_W'(k) < iIndex))) begin
                w_count = w_count + RANK_W'(1);
            end
        end
    end

    assign oRank = w_count;

endmodule

// File: rtl/rank_order_unit.sv
// Three-stage pipelined rank-order selector for a 3x3 window.
// Stage 1 registers the samples and clamped rank index, stage 2 registers
// the per-sample ranks, stage 3 registers the sample whose rank matches.
module rank_order_unit
    import rank_order_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [RANK_W-1:0]   iOrder,
    input  logic [DATA_W-1:0]   iNum1,
    input  logic [DATA_W-1:0]   iNum2,
    input  logic [DATA_W-1:0]   iNum3,
    input  logic [DATA_W-1:0]   iNum4,
    input  logic [DATA_W-1:0]   iNum5,
    input  logic [DATA_W-1:0]   iNum6,
    input  logic [DATA_W-1:0]   iNum7,
    input  logic [DATA_W-1:0]   iNum8,
    input  logic [DATA_W-1:0]   iNum9,
    output logic [DATA_W-1:0]   oValue
);

    logic [N_TAPS-1:0][DATA_W-1:0] w_inSamples;

    logic [N_TAPS-1:0][DATA_W-1:0] r_s1Samples;
    logic [RANK_W-1:0]             r_s1Order;

    logic [N_TAPS-1:0][RANK_W-1:0] w_ranks;

    logic [N_TAPS-1:0][DATA_W-1:0] r_s2Samples;
    logic [N_TAPS-1:0][RANK_W-1:0] r_s2Ranks;
    logic [RANK_W-1:0]             r_s2Order;

    logic [DATA_W-1:0]             w_selected;
    logic [DATA_W-1:0]             r_value;

    // Element 0 is iNum1; the index only matters for tie-breaking.
    assign w_inSamples = {iNum9, iNum8, iNum7, iNum6, iNum5,
                          iNum4, iNum3, iNum2, iNum1};

    // Stage 1: capture the window and the clamped rank index.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_s1Samples <= '0;
            r_s1Order   <= '0;
        end else begin
            r_s1Samples <= w_inSamples;
            r_s1Order   <= clampRankIndex(iOrder);
        end
    end

    // Nine rank counters, each seeing its own sample plus the other eight.
    for (genvar g = 0; g < N_TAPS; g++) begin : gRank
        logic [N_TAPS-2:0][DATA_W-1:0] w_others;

        for (genvar k = 0; k < N_TAPS - 1; k++) begin : gOther
            assign w_others[k] = r_s1Samples[(k < g) ? k : k + 1];
        end

        rank_count #(
            .DATA_W (DATA_W)
        ) uRankCount (
            .iSample (r_s1Samples[g]),
            .iIndex  (RANK_W'(g)),
            .iOthers (w_others),
            .oRank   (w_ranks[g])
        );
    end

    // Stage 2: register ranks with their samples and the travelling order.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_s2Samples <= '0;
            r_s2Ranks   <= '0;
            r_s2Order   <= '0;
        end else begin
            r_s2Samples <= r_s1Samples;
            r_s2Ranks   <= w_ranks;
            r_s2Order   <= r_s1Order;
        end
    end

    // One-hot select: exactly one rank equals the order, so an OR-reduce
    // of the masked samples yields that sample.
    always_comb begin
        w_selected = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            w_selected = w_selected |
                (r_s2Samples[i] & {DATA_W{r_s2Ranks[i] == r_s2Order}});
        end
    end

    // Stage 3: register the selected sample as the output.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_value <= '0;
        end else begin
            r_value <= w_selected;
        end
    end

    assign oValue = r_value;

endmodule

// File: tb/tb_rank_order_unit.sv
// Self-checking bench for rank_order_unit: directed windows plus a random
// back-to-back stream compared against a sort-based reference model.
module tb_rank_order_unit;

    logic       iClk = 1'b0;
    logic       iRst;
    logic [3:0] iOrder;
    logic [7:0] iNum1, iNum2, iNum3, iNum4, iNum5, iNum6, iNum7, iNum8, iNum9;
    logic [7:0] oValue;

    int testsRun    = 0;
    int testsFailed = 0;

    // 100 MHz free-running clock.
    always #5 iClk = ~iClk;

    rank_order_unit #(
        .DATA_W (8)
    ) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iOrder (iOrder),
        .iNum1  (iNum1),
        .iNum2  (iNum2),
        .iNum3  (iNum3),
        .iNum4  (iNum4),
        .iNum5  (iNum5),
        .iNum6  (iNum6),
        .iNum7  (iNum7),
        .iNum8  (iNum8),
        .iNum9  (iNum9),
        .oValue (oValue)
    );

    // Present one window and requested rank on the inputs.
    task automatic applyStimulus(input logic [7:0] w[9], input int ord);
        iNum1  = w[0];
        iNum2  = w[1];
        iNum3  = w[2];
        iNum4  = w[3];
        iNum5  = w[4];
        iNum6  = w[5];
        iNum7  = w[6];
        iNum8  = w[7];
        iNum9  = w[8];
        iOrder = 4'(ord);
    endtask

    // Advance one rising edge and settle away from it.
    task automatic stepEdge();
        @(posedge iClk);
        #1;
    endtask

    // Reference: sort the window and pick the clamped 1-based rank.
    function automatic logic [7:0] refSelect(input logic [7:0] w[9], input int ord);
        int a[9];
        int tmp;
        int r;
        for (int i = 0; i < 9; i++) a[i] = int'(w[i]);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (a[j] > a[j+1]) begin
                    tmp    = a[j];
                    a[j]   = a[j+1];
                    a[j+1] = tmp;
                end
            end
        end
        r = (ord < 1) ? 1 : ((ord > 9) ? 9 : ord);
        return 8'(a[r-1]);
    endfunction

    function automatic logic [7:0] randSample();
        if ($urandom_range(0, 1) == 0) return 8'($urandom_range(0, 7));
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic test_reset();
        logic [7:0] w[9];
        logic [7:0] first[9];
        iRst = 1'b1;
        for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(1, 255));
        applyStimulus(w, 9);
        stepEdge();
        stepEdge();
        testsRun++;
        if (oValue !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_hold: got %0h expected 00", oValue);
        end
        iRst  = 1'b0;
        first = '{8'd30, 8'd10, 8'd50, 8'd20, 8'd40, 8'd60, 8'd70, 8'd90, 8'd80};
        applyStimulus(first, 9);
        for (int e = 1; e <= 3; e++) begin
            stepEdge();
            testsRun++;
            if (e < 3 && oValue !== 8'h00) begin
                testsFailed++;
                $display("[TB] FAIL reset_flush_edge%0d: got %0h expected 00", e, oValue);
            end else if (e == 3 && oValue !== 8'd90) begin
                testsFailed++;
                $display("[TB] FAIL reset_first_data: got %0d expected 90", oValue);
            end
        end
    endtask

    task automatic test_plan_vectors();
        logic [7:0] w[9];
        int orders[4];
        int expect_v[4];
        w        = '{8'd4, 8'd0, 8'd9, 8'd7, 8'd6, 8'd4, 8'd4, 8'd0, 8'd4};
        orders   = '{7, 5, 1, 9};
        expect_v = '{6, 4, 0, 9};
        for (int t = 0; t < 4; t++) begin
            applyStimulus(w, orders[t]);
            stepEdge();
            stepEdge();
            stepEdge();
            testsRun++;
            if (oValue !== 8'(expect_v[t])) begin
                testsFailed++;
                $display("[TB] FAIL plan_order%0d: got %0d expected %0d",
                         orders[t], oValue, expect_v[t]);
            end
        end
    endtask

    task automatic test_hold_switch();
        logic [7:0] w[9];
        w = '{8'd4, 8'd0, 8'd9, 8'd7, 8'd6, 8'd0, 8'd4, 8'd0, 8'd4};
        applyStimulus(w, 2);
        for (int e = 1; e <= 3; e++) begin
            stepEdge();
            testsRun++;
            if (e < 3 && oValue !== 8'd9) begin
                testsFailed++;
                $display("[TB] FAIL switch_hold_edge%0d: got %0d expected 9", e, oValue);
            end else if (e == 3 && oValue !== 8'd0) begin
                testsFailed++;
                $display("[TB] FAIL switch_new: got %0d expected 0", oValue);
            end
        end
    endtask

    task automatic test_ties();
        logic [7:0] w[9];
        for (int i = 0; i < 9; i++) w[i] = 8'hAA;
        for (int ord = 1; ord <= 9; ord++) begin
            applyStimulus(w, ord);
            stepEdge();
            stepEdge();
            stepEdge();
            testsRun++;
            if (oValue !== 8'hAA) begin
                testsFailed++;
                $display("[TB] FAIL ties_order%0d: got %0h expected aa", ord, oValue);
            end
        end
    endtask

    task automatic test_clamp();
        logic [7:0] w[9];
        int orders[3];
        int expect_v[3];
        for (int i = 0; i < 9; i++) w[i] = 8'(9 - i);
        orders   = '{0, 15, 3};
        expect_v = '{1, 9, 3};
        for (int t = 0; t < 3; t++) begin
            applyStimulus(w, orders[t]);
            stepEdge();
            stepEdge();
            stepEdge();
            testsRun++;
            if (oValue !== 8'(expect_v[t])) begin
                testsFailed++;
                $display("[TB] FAIL clamp_order%0d: got %0d expected %0d",
                         orders[t], oValue, expect_v[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w[9];
        logic [7:0] expQ[$];
        logic [7:0] exp_v;
        int ord;
        for (int c = 0; c < 22; c++) begin
            if (c < 20) begin
                for (int i = 0; i < 9; i++) w[i] = randSample();
                ord = int'($urandom_range(0, 15));
                applyStimulus(w, ord);
                expQ.push_back(refSelect(w, ord));
            end
            stepEdge();
            if (c >= 2) begin
                exp_v = expQ.pop_front();
                testsRun++;
                if (oValue !== exp_v) begin
                    testsFailed++;
                    $display("[TB] FAIL stream_item%0d: got %0d expected %0d",
                             c - 2, oValue, exp_v);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] w[9];
        logic [7:0] post[9];
        logic [7:0] exp_v;
        for (int i = 0; i < 9; i++) w[i] = 8'hFF;
        applyStimulus(w, 5);
        stepEdge();
        stepEdge();
        stepEdge();
        testsRun++;
        if (oValue !== 8'hFF) begin
            testsFailed++;
            $display("[TB] FAIL midreset_pre: got %0h expected ff", oValue);
        end
        iRst = 1'b1;
        stepEdge();
        testsRun++;
        if (oValue !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL midreset_edge: got %0h expected 00", oValue);
        end
        iRst = 1'b0;
        for (int i = 0; i < 9; i++) post[i] = 8'($urandom_range(1, 255));
        applyStimulus(post, 4);
        exp_v = refSelect(post, 4);
        stepEdge();
        for (int i = 0; i < 9; i++) w[i] = randSample();
        applyStimulus(w, 9);
        for (int e = 1; e <= 3; e++) begin
            if (e > 1) stepEdge();
            testsRun++;
            if (e < 3 && oValue !== 8'h00) begin
                testsFailed++;
                $display("[TB] FAIL midreset_flush_edge%0d: got %0h expected 00", e, oValue);
            end else if (e == 3 && oValue !== exp_v) begin
                testsFailed++;
                $display("[TB] FAIL midreset_first_data: got %0d expected %0d", oValue, exp_v);
            end
        end
    endtask

    // Run every scenario in sequence, then report.
    initial begin
        iRst   = 1'b1;
        iOrder = 4'd0;
        iNum1 = 8'd0; iNum2 = 8'd0; iNum3 = 8'd0; iNum4 = 8'd0; iNum5 = 8'd0;
        iNum6 = 8'd0; iNum7 = 8'd0; iNum8 = 8'd0; iNum9 = 8'd0;
        test_reset();
        test_plan_vectors();
        test_hold_switch();
        test_ties();
        test_clamp();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
